w_74hc153_mux: RTL and testbench

W_74HC153_MUX -- requirements
Module: w_74hc153_mux

---
 rtl/w_74hc153_pkg.sv | 16 +
 rtl/w_74hc153_mux4_core.sv | 30 +++
 rtl/w_74hc153_mux.sv | 54 +++++
 tb/tb_w_74hc153_mux.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_74hc153_pkg.sv
// Shared select encoding for the 74HC153-style 4:1 data selector.
// Sel1 is the MSB of the select index.
package w_74hc153_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0 = 2'b00;
    localparam sel_t SEL_D1 = 2'b01;
    localparam sel_t SEL_D2 = 2'b10;
    localparam sel_t SEL_D3 = 2'b11;

    function automatic sel_t make_sel(input logic sel1, input logic sel0);
        return {sel1, sel0};
    endfunction

endpackage

// File: rtl/w_74hc153_mux4_core.sv
// Purpose: combinational WIDTH-bit 4:1 selector with active-low strobe.
// Latency: zero (pure combinational).
// Backpressure: none; output follows inputs continuously.
module w_74hc153_mux4_core
    import w_74hc153_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  sel_t             sel,
    input  logic             en_n,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        if (!en_n) begin
            case (sel)
                SEL_D0:  y = d0;
                SEL_D1:  y = d1;
                SEL_D2:  y = d2;
                default: y = d3;
            endcase
        end
    end

endmodule

// File: rtl/w_74hc153_mux.sv
// Purpose: 74HC153-style 4:1 selector; W74HC153_COMB_OUT_EN makes Result combinational.
// Latency: 1 clk registered (default), 0 with W74HC153_COMB_OUT_EN.
// Backpressure: none; accepts a new selection every cycle, reset forces Result to zero.
module w_74hc153_mux
    import w_74hc153_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic             Sel0,
    input  logic             Sel1,
    input  logic             En_n,
    output logic [WIDTH-1:0] Result
);

    sel_t             sel;
    logic [WIDTH-1:0] mux_dat;

    assign sel = make_sel(Sel1, Sel0);

    w_74hc153_mux4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d0   (D0),
        .d1   (D1),
        .d2   (D2),
        .d3   (D3),
        .sel  (sel),
        .en_n (En_n),
        .y    (mux_dat)
    );

`ifdef W74HC153_COMB_OUT_EN
    // Clock has no role in this build; kept on the port list for drop-in compatibility.
    logic unused_clk;
    assign unused_clk = clk;

    assign Result = rst_n ? mux_dat : '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result <= '0;
        end else begin
            Result <= mux_dat;
        end
    end
`endif

endmodule

// File: tb/tb_w_74hc153_mux.sv
`timescale 1ns/1ps
module tb_w_74hc153_mux;

`ifdef W74HC153_COMB_OUT_EN
    localparam bit COMB = 1'b1;
`else
    localparam bit COMB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic [0:0] a_d0, a_d1, a_d2, a_d3;
    logic       a_s0, a_s1, a_en_n;
    logic [0:0] a_res;

    logic [7:0] b_d0, b_d1, b_d2, b_d3;
    logic       b_s0, b_s1, b_en_n;
    logic [7:0] b_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    w_74hc153_mux #(.WIDTH(1)) dut_w1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .D0     (a_d0),
        .D1     (a_d1),
        .D2     (a_d2),
        .D3     (a_d3),
        .Sel0   (a_s0),
        .Sel1   (a_s1),
        .En_n   (a_en_n),
        .Result (a_res)
    );

    w_74hc153_mux #(.WIDTH(8)) dut_w8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .D0     (b_d0),
        .D1     (b_d1),
        .D2     (b_d2),
        .D3     (b_d3),
        .Sel0   (b_s0),
        .Sel1   (b_s1),
        .En_n   (b_en_n),
        .Result (b_res)
    );

    task automatic set_a(input logic d0, input logic d1, input logic d2, input logic d3,
                         input logic [1:0] sel, input logic en_n);
        a_d0 = d0; a_d1 = d1; a_d2 = d2; a_d3 = d3;
        a_s1 = sel[1]; a_s0 = sel[0]; a_en_n = en_n;
    endtask

    task automatic set_b(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [1:0] sel, input logic en_n);
        b_d0 = d0; b_d1 = d1; b_d2 = d2; b_d3 = d3;
        b_s1 = sel[1]; b_s0 = sel[0]; b_en_n = en_n;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_a(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        set_b(8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
        #1;
        total++;
        if (a_res !== 1'b0) begin
            bad++; $display("FAIL reset_w1: got %0h want 0", a_res);
        end
        total++;
        if (b_res !== 8'h00) begin
            bad++; $display("FAIL reset_w8: got %0h want 00", b_res);
        end
        @(posedge clk); #1;
        total++;
        if (a_res !== 1'b0) begin
            bad++; $display("FAIL reset_hold: got %0h want 0", a_res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (a_res !== (COMB ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL reset_release_pre: got %0h want %0h", a_res, COMB);
        end
        @(posedge clk); #1;
        total++;
        if (a_res !== 1'b1) begin
            bad++; $display("FAIL reset_release_load: got %0h want 1", a_res);
        end
    endtask

    task automatic test_sel_sweep;
        logic [1:0] sels [4];
        logic       exps [4];
        logic       prev;
        sels = '{2'b00, 2'b01, 2'b10, 2'b11};
        exps = '{1'b1, 1'b0, 1'b0, 1'b1};

        @(negedge clk);
        set_a(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        #1;
        total++;
        if (a_res !== (COMB ? 1'b0 : 1'b1)) begin
            bad++; $display("FAIL sweep_zero_pre: got %0h want %0h", a_res, ~COMB);
        end
        @(posedge clk); #1;
        total++;
        if (a_res !== 1'b0) begin
            bad++; $display("FAIL sweep_zero: got %0h want 0", a_res);
        end
        prev = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_a(1'b1, 1'b0, 1'b0, 1'b1, sels[i], 1'b0);
            #1;
            total++;
            if (a_res !== (COMB ? exps[i] : prev)) begin
                bad++; $display("FAIL sweep_pre_%0d: got %0h want %0h", i, a_res, COMB ? exps[i] : prev);
            end
            @(posedge clk); #1;
            total++;
            if (a_res !== exps[i]) begin
                bad++; $display("FAIL sweep_step_%0d: got %0h want %0h", i, a_res, exps[i]);
            end
            repeat (9) @(posedge clk);
            #1;
            total++;
            if (a_res !== exps[i]) begin
                bad++; $display("FAIL sweep_hold_%0d: got %0h want %0h", i, a_res, exps[i]);
            end
            prev = exps[i];
        end
    endtask

    task automatic test_strobe;
        @(negedge clk);
        set_a(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        #1;
        total++;
        if (a_res !== (COMB ? 1'b0 : 1'b1)) begin
            bad++; $display("FAIL strobe_off_pre: got %0h want %0h", a_res, ~COMB);
        end
        @(posedge clk); #1;
        total++;
        if (a_res !== 1'b0) begin
            bad++; $display("FAIL strobe_off: got %0h want 0", a_res);
        end
        @(negedge clk);
        a_en_n = 1'b0;
        #1;
        total++;
        if (a_res !== (COMB ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL strobe_on_pre: got %0h want %0h", a_res, COMB);
        end
        @(posedge clk); #1;
        total++;
        if (a_res !== 1'b1) begin
            bad++; $display("FAIL strobe_on: got %0h want 1", a_res);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (a_res !== 1'b0) begin
            bad++; $display("FAIL async_reset_immediate: got %0h want 0", a_res);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (a_res !== 1'b0) begin
            bad++; $display("FAIL async_reset_hold: got %0h want 0", a_res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (a_res !== (COMB ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL async_release_pre: got %0h want %0h", a_res, COMB);
        end
        @(posedge clk); #1;
        total++;
        if (a_res !== 1'b1) begin
            bad++; $display("FAIL async_release_load: got %0h want 1", a_res);
        end
    endtask

    task automatic test_width;
        logic [1:0] sels [4];
        logic [7:0] exps [4];
        logic [7:0] prev;
        sels = '{2'b00, 2'b01, 2'b10, 2'b11};
        exps = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        prev = 8'h00;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_b(8'hA5, 8'h3C, 8'hFF, 8'h00, sels[i], 1'b0);
            #1;
            total++;
            if (b_res !== (COMB ? exps[i] : prev)) begin
                bad++; $display("FAIL width_pre_%0d: got %0h want %0h", i, b_res, COMB ? exps[i] : prev);
            end
            @(posedge clk); #1;
            total++;
            if (b_res !== exps[i]) begin
                bad++; $display("FAIL width_sel_%0d: got %0h want %0h", i, b_res, exps[i]);
            end
            prev = exps[i];
        end
        @(negedge clk);
        set_b(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        b_en_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (b_res !== 8'h00) begin
            bad++; $display("FAIL width_strobe: got %0h want 00", b_res);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] sels [6];
        logic       ens  [6];
        logic       exps [6];
        sels = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
        ens  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        exps = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_a(1'b0, 1'b1, 1'b1, 1'b0, sels[i], ens[i]);
            @(posedge clk); #1;
            total++;
            if (a_res !== exps[i]) begin
                bad++; $display("FAIL b2b_%0d: got %0h want %0h", i, a_res, exps[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sel_sweep();
        test_strobe();
        test_async_reset();
        test_width();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
